// File: rtl/sequence_generator_fsm.sv
// sequence_generator_fsm
//   Serial pattern transmitter. A WIDTH-bit pattern and a repeat count are
//   accepted over a valid/ready handshake. The pattern is then sent MSB-first,
//   one bit per clock, repeat_n times. GAP idle cycles are inserted between
//   repetitions. The serial output feeds the 1-bit "a" input of the
//   sequence-detector FSMs.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start_valid  request to send a pattern
//   start_ready  request can be accepted (IDLE only)
//   pattern      pattern to send, sampled on the handshake
//   repeat_n     number of repetitions, sampled on the handshake
//   abort        synchronous cancel of the current transfer
//   a            serial data bit
//   a_valid      a carries a pattern bit this cycle
//   busy         transfer in progress (SEND or GAP)
//   done         one-cycle pulse on normal completion
module sequence_generator_fsm #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic             abort,
  output logic             a,
  output logic             a_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BC_W = $clog2(WIDTH);
  localparam int unsigned GC_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(WIDTH - 1);
  localparam logic [GC_W-1:0] GAP_LAST = GC_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] shift_q,   shift_d;
  logic [WIDTH-1:0] hold_q,    hold_d;
  logic [CNT_W-1:0] rep_q,     rep_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GC_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic             done_q,    done_d;
  logic             ready_q,   ready_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      hold_q    <= '0;
      rep_q     <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_valid && ready_q) begin
          hold_d    = pattern;
          shift_d   = pattern;
          rep_d     = repeat_n;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          // A zero repeat count completes at once without leaving IDLE.
          if (repeat_n == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_SEND;
          end
        end
      end

      S_SEND: begin
        // abort wins over the end-of-repetition decision.
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (rep_q > CNT_W'(1)) begin
            rep_d = rep_q - CNT_W'(1);
            if (GAP == 0) begin
              shift_d = hold_q;
            end else begin
              state_d   = S_GAP;
              gap_cnt_d = '0;
            end
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          shift_d   = {shift_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end

      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q == GAP_LAST) begin
          shift_d = hold_q;
          state_d = S_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q + GC_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Registered ready follows the next state, so it is already high in the
    // done cycle and stays low through the reset cycle.
    ready_d = (state_d == S_IDLE);
  end

  assign a_valid     = (state_q == S_SEND);
  assign a           = a_valid & shift_q[WIDTH-1];
  assign busy        = (state_q == S_SEND) || (state_q == S_GAP);
  assign done        = done_q;
  assign start_ready = ready_q;

endmodule

// File: tb/tb_sequence_generator_fsm.sv
module tb_sequence_generator_fsm;

  localparam int W  = 6;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_valid = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  pattern = '0;
  logic [CW-1:0] repeat_n = '0;

  logic sr0, a0, av0, bz0, dn0;
  logic sr1, a1, av1, bz1, dn1;

  sequence_generator_fsm #(.WIDTH(W), .CNT_W(CW), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr0),
    .pattern(pattern), .repeat_n(repeat_n), .abort(abort),
    .a(a0), .a_valid(av0), .busy(bz0), .done(dn0)
  );

  sequence_generator_fsm #(.WIDTH(W), .CNT_W(CW), .GAP(2)) dut1 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr1),
    .pattern(pattern), .repeat_n(repeat_n), .abort(abort),
    .a(a1), .a_valid(av1), .busy(bz1), .done(dn1)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: on accept, the whole expected output timeline of the
  // transfer is laid out as a list of {a, a_valid, busy, done} entries, one per
  // cycle; each clock consumes one entry. Idle is all zeros.
  logic [3:0] seq [2][512];
  int         len [2] = '{0, 0};
  int         rd  [2] = '{0, 0};
  logic [3:0] cur [2] = '{4'b0, 4'b0};
  logic       rdy [2] = '{1'b0, 1'b0};
  int         cyc [2] = '{0, 0};

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        cur[d] = 4'b0;
        rdy[d] = 1'b0;
        len[d] = 0;
        rd[d]  = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (abort && cur[d][1]) begin
          len[d] = 0;
          rd[d]  = 0;
        end else if (start_valid && rdy[d]) begin
          len[d] = 0;
          rd[d]  = 0;
          for (int r = 0; r < int'(repeat_n); r++) begin
            if (r > 0)
              for (int g = 0; g < gap_of(d); g++) begin
                seq[d][len[d]] = 4'b0010;
                len[d]++;
              end
            for (int i = W - 1; i >= 0; i--) begin
              seq[d][len[d]] = {pattern[i], 3'b110};
              len[d]++;
            end
          end
          seq[d][len[d]] = 4'b0001;
          len[d]++;
          cyc[d] = 0;
        end
        cyc[d]++;
        if (rd[d] < len[d]) begin
          cur[d] = seq[d][rd[d]];
          rd[d]++;
        end else begin
          cur[d] = 4'b0;
        end
        rdy[d] = !cur[d][1];
      end
    end
  end

  // Per-cycle comparison, plus capture of emitted bits and the done cycle
  // for the literal checks in the directed tests.
  logic [31:0] cap     [2] = '{32'd0, 32'd0};
  int          done_at [2] = '{0, 0};

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic [4:0] act;
      logic [4:0] expv;
      act  = (d == 0) ? {a0, av0, bz0, dn0, sr0} : {a1, av1, bz1, dn1, sr1};
      expv = {cur[d], rdy[d]};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL cycle_dut%0d {a,a_valid,busy,done,start_ready} got %b expected %b at %0t",
                 d, act, expv, $time);
      end
      if (act[3]) cap[d] = {cap[d][30:0], act[4]};
      if (act[1]) done_at[d] = cyc[d];
      if (start_valid && rdy[d]) begin
        cap[d]     = 32'd0;
        done_at[d] = 0;
      end
    end
  end

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, expv, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(rdy[0] && rdy[1]) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout got busy expected idle within 300 cycles");
    end
  endtask

  // Leaves the bench in cycle 1 after the accepting edge, with the inputs
  // scrambled to show they are ignored outside the handshake.
  task automatic send(input logic [W-1:0] p, input logic [CW-1:0] n);
    wait_idle();
    start_valid = 1'b1;
    pattern     = p;
    repeat_n    = n;
    tick();
    start_valid = 1'b0;
    pattern     = W'($urandom);
    repeat_n    = CW'($urandom);
  endtask

  initial begin
    #12;
    chk("reset_outs_dut0", int'({a0, av0, bz0, dn0, sr0}), 0);
    chk("reset_outs_dut1", int'({a1, av1, bz1, dn1, sr1}), 0);
    #10 rst = 1'b1;
    tick();
    chk("ready_after_reset", int'({sr1, sr0}), 3);

    send(6'b110011, 4'd1);
    repeat (8) tick();
    chk("rep1_bits_dut0", int'(cap[0]), 32'b110011);
    chk("rep1_done_dut0", done_at[0], 7);
    chk("rep1_bits_dut1", int'(cap[1]), 32'b110011);
    chk("rep1_done_dut1", done_at[1], 7);

    send(6'b110011, 4'd2);
    repeat (14) tick();
    chk("rep2_bits_dut0", int'(cap[0]), 32'b110011110011);
    chk("rep2_done_dut0", done_at[0], 13);

    send(6'b101000, 4'd2);
    repeat (16) tick();
    chk("gap2_bits_dut1", int'(cap[1]), 32'b101000101000);
    chk("gap2_done_dut1", done_at[1], 15);
    chk("gap0_done_dut0", done_at[0], 13);

    send(6'b111111, 4'd0);
    chk("rep0_ready_dut0", int'(sr0), 1);
    repeat (3) tick();
    chk("rep0_done_dut0", done_at[0], 1);
    chk("rep0_done_dut1", done_at[1], 1);
    chk("rep0_nobits_dut0", int'(cap[0]), 0);

    send(6'b100110, 4'd3);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid_drop", int'({av1, av0}), 0);
    chk("abort_ready", int'({sr1, sr0}), 3);
    chk("abort_bits_dut0", int'(cap[0]), 32'b1001);
    repeat (20) tick();
    chk("abort_no_done", done_at[0], 0);
    send(6'b011010, 4'd1);
    repeat (8) tick();
    chk("post_abort_bits", int'(cap[0]), 32'b011010);
    chk("post_abort_done", done_at[0], 7);

    send(6'b111111, 4'd3);
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    chk("midrst_outs_dut0", int'({a0, av0, bz0, dn0, sr0}), 0);
    chk("midrst_outs_dut1", int'({a1, av1, bz1, dn1, sr1}), 0);
    #3 rst = 1'b1;
    tick();
    chk("midrst_ready", int'({sr1, sr0}), 3);
    send(6'b010101, 4'd2);
    repeat (14) tick();
    chk("midrst_bits_dut0", int'(cap[0]), 32'b010101010101);
    chk("midrst_done_dut0", done_at[0], 13);

    for (int k = 0; k < 500; k++) begin
      start_valid = ($urandom % 3) != 0;
      pattern     = W'($urandom);
      repeat_n    = (($urandom % 8) == 0) ? CW'($urandom) : CW'($urandom % 4);
      abort       = ($urandom % 40) == 0;
      tick();
    end
    start_valid = 1'b0;
    abort       = 1'b0;
    repeat (150) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
